// File: rtl/fetch_prefetch_ctrl.sv
// Pipelined instruction-fetch controller: issues sequential icache reads with up to
// MAX_OUTS in flight, buffers returned instructions in order, and flushes on redirect.
module fetch_prefetch_ctrl #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INST_W   = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        MAX_OUTS = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              firing,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              arvalid_o,
  output logic [ADDR_W-1:0] araddr_o,
  input  logic              arready_i,
  input  logic              rvalid_i,
  input  logic [INST_W-1:0] rdata_i,
  output logic              rready_o,
  output logic              valid_post_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  input  logic              ready_post_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned OW = PW + 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic              hold_q, hold_d;
  logic [PW-1:0]     inflight_q, inflight_d;
  logic [PW-1:0]     stale_q, stale_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic          run, empty, credit_ok, ar_fire, r_fire, pop, push;
  logic [PW-1:0] count;
  logic [OW-1:0] occupancy;

  assign run       = (state_q == RUN);
  assign count     = wptr_q - rptr_q;
  assign empty     = (wptr_q == rptr_q);
  assign occupancy = OW'(count) + OW'(inflight_q);
  assign credit_ok = (inflight_q < PW'(MAX_OUTS)) && (occupancy < OW'(DEPTH));

  // A request caught by a redirect before it was accepted keeps its old address
  // (hold_q); it is marked stale only once it actually fires.
  assign arvalid_o    = run & (hold_q | credit_ok);
  assign araddr_o     = hold_q ? hold_addr_q : fetch_pc_q;
  assign rready_o     = run;
  assign valid_post_o = run & ~empty & ~redirect_i;
  assign pc_o         = pc_mem[rptr_q[AW-1:0]];
  assign inst_o       = inst_mem[rptr_q[AW-1:0]];

  assign ar_fire = arvalid_o & arready_i;
  assign r_fire  = rvalid_i & rready_o;
  assign pop     = valid_post_o & ready_post_i;
  assign push    = r_fire & ~redirect_i & (stale_q == '0);

  // NOTE: every next-state signal gets its hold value first so no path leaves it
  // unassigned; skipping the defaults is how latches get inferred here.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    hold_d      = hold_q;
    hold_addr_d = hold_addr_q;
    inflight_d  = inflight_q + PW'(ar_fire) - PW'(r_fire);
    stale_d     = stale_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;

    if (state_q == IDLE) begin
      if (redirect_i) begin
        fetch_pc_d = redirect_pc_i;
        resp_pc_d  = redirect_pc_i;
      end
      if (firing) state_d = RUN;
    end else begin
      if (ar_fire) begin
        if (hold_q) hold_d = 1'b0;
        else        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      stale_d = stale_q + PW'(ar_fire & hold_q) - PW'(r_fire & (stale_q != '0));
      if (push) begin
        wptr_d    = wptr_q + PW'(1);
        resp_pc_d = resp_pc_q + ADDR_W'(4);
      end
      if (pop) rptr_d = rptr_q + PW'(1);

      // Redirect overrides everything above: all older requests become stale.
      if (redirect_i) begin
        wptr_d     = '0;
        rptr_d     = '0;
        stale_d    = inflight_d;
        fetch_pc_d = redirect_pc_i;
        resp_pc_d  = redirect_pc_i;
        if (arvalid_o && !arready_i && !hold_q) begin
          hold_d      = 1'b1;
          hold_addr_d = fetch_pc_q;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      hold_q      <= 1'b0;
      hold_addr_q <= RESET_PC;
      inflight_q  <= '0;
      stale_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      hold_q      <= hold_d;
      hold_addr_q <= hold_addr_d;
      inflight_q  <= inflight_d;
      stale_q     <= stale_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  // NOTE: queue storage is not reset; the pointers alone define which entries are
  // valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wptr_q[AW-1:0]]   <= resp_pc_q;
      inst_mem[wptr_q[AW-1:0]] <= rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_ctrl.sv
// Scoreboard bench for fetch_prefetch_ctrl: an in-order icache model plus an
// expected-PC stream (sequential from each start/redirect target) checked at decode.
module tb_fetch_prefetch_ctrl;

  localparam int          ADDR_W   = 32;
  localparam int          INST_W   = 32;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUTS = 2;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset, firing, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        arvalid_o, arready_i, rvalid_i, rready_o;
  logic [31:0] araddr_o, rdata_i, pc_o, inst_o;
  logic        valid_post_o, ready_post_i;

  always #5 clock = ~clock;

  fetch_prefetch_ctrl #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .MAX_OUTS(MAX_OUTS), .RESET_PC(RESET_PC)
  ) dut (
    .clock(clock), .reset(reset), .firing(firing),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arready_i(arready_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rready_o(rready_o),
    .valid_post_o(valid_post_o), .pc_o(pc_o), .inst_o(inst_o), .ready_post_i(ready_post_i)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Icache contents: a fixed scramble of the address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
  endfunction

  typedef struct {
    logic [31:0] addr;
    longint      rdy;
  } req_t;

  req_t        icq[$];
  logic [31:0] exp_q[$];
  logic [31:0] base_pc = RESET_PC;
  logic [31:0] hold_addr;
  bit          running = 0, hold_prev = 0, wrap_chk = 0;
  int          outstanding = 0, ar_cnt = 0, pop_cnt = 0;
  int          ar_pct = 100, rv_pct = 100, rp_pct = 100, lat = 1;
  longint      cyc = 0;

  task automatic fill(input logic [31:0] base);
    logic [31:0] p;
    p = base;
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  // Icache / decode stimulus driver, updated just after each rising edge.
  always @(posedge clock) begin
    cyc++;
    #1;
    arready_i    = (int'($urandom_range(0, 99)) < ar_pct);
    ready_post_i = (int'($urandom_range(0, 99)) < rp_pct);
    if (icq.size() > 0 && icq[0].rdy <= cyc && int'($urandom_range(0, 99)) < rv_pct) begin
      rvalid_i = 1'b1;
      rdata_i  = inst_of(icq[0].addr);
    end else begin
      rvalid_i = 1'b0;
      rdata_i  = $urandom;
    end
  end

  // Monitor: sample on the falling edge, compare, then advance the model for the next edge.
  always @(negedge clock) begin
    logic [31:0] exp_pc;
    bit          ar_fire, r_fire;
    if (reset) begin
      running     = 0;
      hold_prev   = 0;
      wrap_chk    = 0;
      outstanding = 0;
      base_pc     = RESET_PC;
      icq.delete();
      exp_q.delete();
    end else begin
      if (running) begin
        if (hold_prev) begin
          check("ar_hold_valid", arvalid_o, 1);
          check("ar_hold_addr", araddr_o, hold_addr);
        end
        if (wrap_chk) begin
          check("wrap_addr", araddr_o, 0);
          wrap_chk = 0;
        end
        check("inflight_max", outstanding <= MAX_OUTS, 1);
        if (redirect_i) check("no_pop_on_redirect", valid_post_o, 0);
        if (valid_post_o && ready_post_i) begin
          exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
          check("pc", pc_o, exp_pc);
          check("inst", inst_o, inst_of(exp_pc));
          pop_cnt++;
        end
      end else begin
        check("idle_quiet", {arvalid_o, rready_o, valid_post_o}, 0);
      end

      ar_fire   = arvalid_o && arready_i;
      r_fire    = rvalid_i && rready_o;
      hold_prev = running && arvalid_o && !arready_i;
      hold_addr = araddr_o;
      if (ar_fire && araddr_o == 32'hFFFF_FFFC && !redirect_i) wrap_chk = 1;
      if (ar_fire) begin
        icq.push_back('{araddr_o, cyc + lat});
        outstanding++;
        ar_cnt++;
      end
      if (r_fire && icq.size() > 0) begin
        void'(icq.pop_front());
        outstanding--;
      end
      if (redirect_i) begin
        base_pc = redirect_pc_i;
        if (running) fill(base_pc);
      end
      if (!running && firing) begin
        running = 1;
        ar_cnt  = 0;
        fill(base_pc);
      end
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic start();
    firing = 1'b1;
    cycle();
    firing = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    cycle();
    redirect_i    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          p0;
    logic [31:0] a0;
    reset = 1'b1; firing = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; ready_post_i = 1'b0;
    cycle();
    cycle();
    check("rst_arvalid", arvalid_o, 0);
    check("rst_rready", rready_o, 0);
    check("rst_valid_post", valid_post_o, 0);
    check("rst_araddr", araddr_o, RESET_PC);
    reset = 1'b0;
    cycle();

    // Streaming with a 1-cycle icache: one instruction per cycle.
    start();
    repeat (6) cycle();
    p0 = pop_cnt;
    repeat (20) cycle();
    check("t1_throughput", pop_cnt - p0, 20);

    // Redirect in the same cycle as a response and a pop.
    pulse_redirect(32'h8000_2000);
    check("t5_queue_empty", valid_post_o, 0);
    repeat (20) cycle();

    // Reset mid-stream.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t6_rst_arvalid", arvalid_o, 0);
    check("t6_rst_rready", rready_o, 0);
    check("t6_rst_valid_post", valid_post_o, 0);
    check("t6_rst_araddr", araddr_o, RESET_PC);

    // Decode stalled: queue fills to DEPTH, head stays put.
    rp_pct = 0;
    do_reset();
    start();
    repeat (12) cycle();
    check("t2_ar_count", ar_cnt, DEPTH);
    check("t2_arvalid_low", arvalid_o, 0);
    check("t2_valid_held", valid_post_o, 1);
    check("t2_head_pc", pc_o, RESET_PC);
    check("t2_head_inst", inst_o, inst_of(RESET_PC));
    rp_pct = 100;
    repeat (12) cycle();

    // Redirect with two requests outstanding in a slow icache.
    lat = 6;
    do_reset();
    start();
    repeat (4) cycle();
    check("t3_outstanding", outstanding, 2);
    pulse_redirect(32'h8000_1000);
    lat = 1;
    for (int i = 0; i < 40 && !valid_post_o; i++) cycle();
    check("t3_valid_seen", valid_post_o, 1);
    check("t3_first_pc", pc_o, 32'h8000_1000);
    repeat (10) cycle();

    // Redirect while a request is held waiting for arready.
    ar_pct = 0;
    do_reset();
    start();
    repeat (3) cycle();
    check("t4_arvalid", arvalid_o, 1);
    a0 = araddr_o;
    check("t4_addr", a0, RESET_PC);
    pulse_redirect(32'h8000_3000);
    repeat (3) begin
      check("t4_addr_held", araddr_o, a0);
      cycle();
    end
    ar_pct = 100;
    for (int i = 0; i < 10 && araddr_o == a0; i++) cycle();
    check("t4_next_addr", araddr_o, 32'h8000_3000);
    repeat (20) cycle();

    // PC wrap at the top of the address space (target loaded while idle).
    do_reset();
    pulse_redirect(32'hFFFF_FFF8);
    start();
    repeat (20) cycle();

    // Randomized traffic with sporadic redirects.
    do_reset();
    start();
    p0 = pop_cnt;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        ar_pct = int'($urandom_range(30, 100));
        rv_pct = int'($urandom_range(30, 100));
        rp_pct = int'($urandom_range(20, 100));
        lat    = int'($urandom_range(1, 5));
      end
      redirect_i    = (int'($urandom_range(0, 99)) < 3);
      redirect_pc_i = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    redirect_i = 1'b0;
    ar_pct = 100; rv_pct = 100; rp_pct = 100; lat = 1;
    repeat (60) cycle();
    check("random_progress", (pop_cnt - p0) > 200, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
